// File: rtl/arilla_lsu_pkg.sv
// Shared types and helpers for the arilla load/store master.
// Optional split-beat support is enabled by defining ARILLA_LSU_MISALIGNED_EN.
package arilla_lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } state_e;

  function automatic int size_bytes(size_e size);
    return 1 << size;
  endfunction

endpackage

// File: rtl/arilla_bus_if.sv
// Word-addressed arilla bus with a shared tri-state data path.
// The slave answers combinationally in the same cycle the master drives a beat.
interface arilla_bus_if #(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
);
  localparam int ByteEnables        = DataWidth / 8;
  localparam int ActualAddressWidth = AddressWidth - $clog2(ByteEnables);

  logic [ActualAddressWidth-1:0] address;
  logic [ByteEnables-1:0]        byte_enable;
  logic                          read;
  logic                          write;
  wire  [DataWidth-1:0]          data;
  logic                          available;
  logic                          intercept;

  modport master (
    output address, byte_enable, read, write,
    inout  data,
    input  available, intercept
  );

  modport slave (
    input  address, byte_enable, read, write,
    inout  data,
    output available, intercept
  );

endinterface

// File: rtl/arilla_lsu_align.sv
// Lane logic for the load/store master: byte enables and write shifting per beat,
// plus merging of the two-beat read buffer into an extended result.
module arilla_lsu_align
  import arilla_lsu_pkg::*;
#(
  parameter int DataWidth   = 32,
  parameter int ByteEnables = DataWidth / 8,
  parameter int OffsetWidth = $clog2(ByteEnables)
) (
  input  size_e                  size,
  input  logic [OffsetWidth-1:0] offset,
  input  logic                   is_unsigned,
  input  logic                   second,
  input  logic [DataWidth-1:0]   wdata,
  input  logic [2*DataWidth-1:0] rbuf,
  output logic [ByteEnables-1:0] byte_enable,
  output logic [DataWidth-1:0]   beat_wdata,
  output logic                   crosses,
  output logic [DataWidth-1:0]   rdata
);

  logic [2*ByteEnables-1:0] be_span;
  logic [2*DataWidth-1:0]   wdata_span;
  logic [DataWidth-1:0]     rbuf_aligned;
  logic [7:0]               sign_byte;
  int                       nbytes;

  // The access is laid out across two words; the upper word is the second beat.
  always_comb begin
    nbytes  = size_bytes(size);
    be_span = '0;
    for (int i = 0; i < 2 * ByteEnables; i++) begin
      if (i < nbytes) be_span[i] = 1'b1;
    end
    be_span     = be_span << offset;
    wdata_span  = {{DataWidth{1'b0}}, wdata} << {offset, 3'b000};
    crosses     = |be_span[2*ByteEnables-1:ByteEnables];
    byte_enable = second ? be_span[2*ByteEnables-1:ByteEnables] : be_span[ByteEnables-1:0];
    beat_wdata  = second ? wdata_span[2*DataWidth-1:DataWidth] : wdata_span[DataWidth-1:0];
  end

  always_comb begin
    rbuf_aligned = DataWidth'(rbuf >> {offset, 3'b000});
    sign_byte    = '0;
    for (int i = 0; i < ByteEnables; i++) begin
      if (i == nbytes - 1) sign_byte = rbuf_aligned[8*i +: 8];
    end
    rdata = '0;
    for (int i = 0; i < ByteEnables; i++) begin
      rdata[8*i +: 8] = (i < nbytes) ? rbuf_aligned[8*i +: 8]
                                     : {8{sign_byte[7] & ~is_unsigned}};
    end
  end

endmodule

// File: rtl/arilla_lsu_master.sv
// Load/store master turning byte-addressed CPU requests into arilla bus beats.
// Define ARILLA_LSU_MISALIGNED_EN to split word-crossing accesses into two beats.
module arilla_lsu_master
  import arilla_lsu_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [AddressWidth-1:0] req_addr,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [DataWidth-1:0]    req_wdata,
  output logic                    rsp_valid,
  output logic [DataWidth-1:0]    rsp_rdata,
  output logic                    rsp_fault,
  output logic                    rsp_intercepted,
  arilla_bus_if.master            bus
);

  localparam int ByteEnables        = DataWidth / 8;
  localparam int OffsetWidth        = $clog2(ByteEnables);
  localparam int ActualAddressWidth = AddressWidth - OffsetWidth;

  state_e                        state;
  logic                          wr_q;
  logic                          uns_q;
  size_e                         size_q;
  logic [OffsetWidth-1:0]        offset_q;
  logic [ActualAddressWidth-1:0] word_q;
  logic [DataWidth-1:0]          wdata_q;
  logic [DataWidth-1:0]          rbuf_lo_q;
`ifdef ARILLA_LSU_MISALIGNED_EN
  logic                          icpt_q;
`endif

  logic [ByteEnables-1:0]   beat_be;
  logic [DataWidth-1:0]     beat_wdata;
  logic [DataWidth-1:0]     beat_rdata;
  logic [DataWidth-1:0]     rdata_ext;
  logic [2*DataWidth-1:0]   rbuf_next;
  logic                     crosses;
  logic                     second;
  logic                     in_beat;
  logic                     beat_done;
  logic                     req_reject;

  assign second    = (state == BEAT1);
  assign in_beat   = (state == BEAT0) || (state == BEAT1);
  assign beat_done = bus.available | bus.intercept;

  arilla_lsu_align #(
    .DataWidth (DataWidth)
  ) u_align (
    .size        (size_q),
    .offset      (offset_q),
    .is_unsigned (uns_q),
    .second      (second),
    .wdata       (wdata_q),
    .rbuf        (rbuf_next),
    .byte_enable (beat_be),
    .beat_wdata  (beat_wdata),
    .crosses     (crosses),
    .rdata       (rdata_ext)
  );

  // Without split support, anything not naturally aligned is refused up front.
  always_comb begin
    req_reject = (req_size == 2'd3) && (DataWidth != 64);
`ifndef ARILLA_LSU_MISALIGNED_EN
    case (size_e'(req_size))
      SIZE_H:  req_reject = req_reject | req_addr[0];
      SIZE_W:  req_reject = req_reject | (|req_addr[1:0]);
      SIZE_D:  req_reject = req_reject | (|req_addr[2:0]);
      default: ;
    endcase
`endif
  end

  always_comb begin
    bus.address     = '0;
    bus.byte_enable = '0;
    bus.read        = 1'b0;
    bus.write       = 1'b0;
    if (in_beat) begin
      bus.address     = second ? word_q + ActualAddressWidth'(1) : word_q;
      bus.byte_enable = beat_be;
      bus.read        = ~wr_q;
      bus.write       = wr_q;
    end
  end

  assign bus.data = (in_beat && wr_q) ? beat_wdata : 'z;

  // Only enabled lanes enter the read buffer; the rest are treated as zero.
  always_comb begin
    beat_rdata = '0;
    for (int i = 0; i < ByteEnables; i++) begin
      if (beat_be[i]) beat_rdata[8*i +: 8] = bus.data[8*i +: 8];
    end
    rbuf_next = second ? {beat_rdata, rbuf_lo_q} : {{DataWidth{1'b0}}, beat_rdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      req_ready       <= 1'b1;
      rsp_valid       <= 1'b0;
      rsp_rdata       <= '0;
      rsp_fault       <= 1'b0;
      rsp_intercepted <= 1'b0;
      wr_q            <= 1'b0;
      uns_q           <= 1'b0;
      size_q          <= SIZE_B;
      offset_q        <= '0;
      word_q          <= '0;
      wdata_q         <= '0;
      rbuf_lo_q       <= '0;
`ifdef ARILLA_LSU_MISALIGNED_EN
      icpt_q          <= 1'b0;
`endif
    end else begin
      rsp_valid       <= 1'b0;
      rsp_rdata       <= '0;
      rsp_fault       <= 1'b0;
      rsp_intercepted <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            wr_q      <= req_write;
            uns_q     <= req_unsigned;
            size_q    <= size_e'(req_size);
            offset_q  <= req_addr[OffsetWidth-1:0];
            word_q    <= req_addr[AddressWidth-1:OffsetWidth];
            wdata_q   <= req_wdata;
            if (req_reject) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_fault <= 1'b1;
            end else begin
              state <= BEAT0;
            end
          end
        end
        BEAT0: begin
          rbuf_lo_q <= beat_rdata;
          state     <= RESP;
          rsp_valid <= 1'b1;
          if (!beat_done) begin
            rsp_fault <= 1'b1;
`ifdef ARILLA_LSU_MISALIGNED_EN
          end else if (crosses) begin
            icpt_q    <= bus.intercept;
            rsp_valid <= 1'b0;
            state     <= BEAT1;
`else
          end else if (crosses) begin
            rsp_fault <= 1'b1;
`endif
          end else begin
            rsp_rdata       <= wr_q ? '0 : rdata_ext;
            rsp_intercepted <= bus.intercept;
          end
        end
`ifdef ARILLA_LSU_MISALIGNED_EN
        BEAT1: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          if (!beat_done) begin
            rsp_fault       <= 1'b1;
            rsp_intercepted <= icpt_q;
          end else begin
            rsp_rdata       <= wr_q ? '0 : rdata_ext;
            rsp_intercepted <= icpt_q | bus.intercept;
          end
        end
`endif
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arilla_lsu_master.sv
// Directed bench for arilla_lsu_master with a same-cycle slave model on the bus.
// Expectations follow ARILLA_LSU_MISALIGNED_EN when it is defined for the build.
module tb_arilla_lsu_master;

  localparam int DataWidth    = 32;
  localparam int AddressWidth = 32;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [AddressWidth-1:0] req_addr;
  logic [1:0]              req_size;
  logic                    req_unsigned;
  logic [DataWidth-1:0]    req_wdata;
  logic                    rsp_valid;
  logic [DataWidth-1:0]    rsp_rdata;
  logic                    rsp_fault;
  logic                    rsp_intercepted;

  logic                    slave_avail;
  logic                    slave_icpt;
  logic [DataWidth-1:0]    slave_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  arilla_bus_if #(.DataWidth(DataWidth), .AddressWidth(AddressWidth)) bus ();

  assign bus.available = slave_avail;
  assign bus.intercept = slave_icpt;
  assign bus.data      = bus.read ? slave_rdata : 'z;

  arilla_lsu_master #(
    .DataWidth    (DataWidth),
    .AddressWidth (AddressWidth)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_size        (req_size),
    .req_unsigned    (req_unsigned),
    .req_wdata       (req_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .rsp_fault       (rsp_fault),
    .rsp_intercepted (rsp_intercepted),
    .bus             (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one request in an idle cycle and leaves the bench in the cycle after acceptance.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                               input logic uns, input logic [31:0] wdata);
    checkOutput("req_ready_idle", req_ready, 1);
    req_write    = wr;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    tick();
    req_valid    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_addr     = '0;
    req_size     = '0;
    req_unsigned = 1'b0;
    req_wdata    = '0;
    slave_avail  = 1'b1;
    slave_icpt   = 1'b0;
    slave_rdata  = '0;
    #12;
    checkOutput("rst_ready", req_ready, 1);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 0);
    checkOutput("rst_rsp_fault", rsp_fault, 0);
    checkOutput("rst_rsp_icpt", rsp_intercepted, 0);
    checkOutput("rst_bus_rd_wr", {bus.read, bus.write}, 0);
    checkOutput("rst_bus_be", bus.byte_enable, 0);
    checkOutput("rst_bus_addr", bus.address, 0);
    rst_n = 1'b1;
    tick();

    // Aligned word load
    slave_rdata = 32'hDEADBEEF;
    applyStimulus(1'b0, 32'h100, 2'd2, 1'b0, 32'h0);
    checkOutput("wl_addr", bus.address, 32'h40);
    checkOutput("wl_be", bus.byte_enable, 4'b1111);
    checkOutput("wl_rd_wr", {bus.read, bus.write}, 2'b10);
    checkOutput("wl_no_rsp_yet", rsp_valid, 0);
    tick();
    checkOutput("wl_rsp_valid", rsp_valid, 1);
    checkOutput("wl_rdata", rsp_rdata, 32'hDEADBEEF);
    checkOutput("wl_fault", rsp_fault, 0);
    checkOutput("wl_icpt", rsp_intercepted, 0);
    checkOutput("wl_ready_resp", req_ready, 0);
    tick();
    checkOutput("wl_rsp_pulse", rsp_valid, 0);
    checkOutput("wl_bus_idle", {bus.read, bus.write}, 0);

    // Signed then unsigned byte load from lane 3
    slave_rdata = 32'h80123456;
    applyStimulus(1'b0, 32'h103, 2'd0, 1'b0, 32'h0);
    checkOutput("bl_be", bus.byte_enable, 4'b1000);
    tick();
    checkOutput("bl_signed", rsp_rdata, 32'hFFFFFF80);
    tick();
    applyStimulus(1'b0, 32'h103, 2'd0, 1'b1, 32'h0);
    tick();
    checkOutput("bl_unsigned", rsp_rdata, 32'h00000080);
    tick();

    // Signed half load from lanes 3..2
    slave_rdata = 32'hBEEF1234;
    applyStimulus(1'b0, 32'h102, 2'd1, 1'b0, 32'h0);
    checkOutput("hl_be", bus.byte_enable, 4'b1100);
    tick();
    checkOutput("hl_rdata", rsp_rdata, 32'hFFFFBEEF);
    tick();

    // Aligned word store and a byte store into lane 1
    applyStimulus(1'b1, 32'h200, 2'd2, 1'b0, 32'h11223344);
    checkOutput("ws_addr", bus.address, 32'h80);
    checkOutput("ws_rd_wr", {bus.read, bus.write}, 2'b01);
    checkOutput("ws_data", bus.data, 32'h11223344);
    tick();
    checkOutput("ws_rsp", {rsp_valid, rsp_fault}, 2'b10);
    checkOutput("ws_rdata", rsp_rdata, 0);
    tick();
    applyStimulus(1'b1, 32'h201, 2'd0, 1'b0, 32'h000000AB);
    checkOutput("bs_be", bus.byte_enable, 4'b0010);
    checkOutput("bs_data", bus.data, 32'h0000AB00);
    tick();
    tick();

    // Misaligned word store crossing into the next word
    applyStimulus(1'b1, 32'h102, 2'd2, 1'b0, 32'h11223344);
`ifdef ARILLA_LSU_MISALIGNED_EN
    checkOutput("ms_b0_addr", bus.address, 32'h40);
    checkOutput("ms_b0_be", bus.byte_enable, 4'b1100);
    checkOutput("ms_b0_data", bus.data, 32'h33440000);
    tick();
    checkOutput("ms_b1_addr", bus.address, 32'h41);
    checkOutput("ms_b1_be", bus.byte_enable, 4'b0011);
    checkOutput("ms_b1_data", bus.data, 32'h00001122);
    checkOutput("ms_no_rsp_yet", rsp_valid, 0);
    tick();
    checkOutput("ms_rsp", {rsp_valid, rsp_fault}, 2'b10);
`else
    checkOutput("ms_no_bus", {bus.read, bus.write}, 0);
    checkOutput("ms_rsp", {rsp_valid, rsp_fault}, 2'b11);
`endif
    tick();

    // Misaligned word load merging both beats
    slave_rdata = 32'hAABB0000;
    applyStimulus(1'b0, 32'h102, 2'd2, 1'b0, 32'h0);
`ifdef ARILLA_LSU_MISALIGNED_EN
    slave_rdata = 32'hAABB0000;
    tick();
    slave_rdata = 32'h0000CCDD;
    tick();
    checkOutput("ml_rsp", {rsp_valid, rsp_fault}, 2'b10);
    checkOutput("ml_rdata", rsp_rdata, 32'hCCDDAABB);
`else
    checkOutput("ml_rsp", {rsp_valid, rsp_fault}, 2'b11);
    checkOutput("ml_rdata", rsp_rdata, 0);
`endif
    tick();

    // Half load at the top of memory; no slave answers the wrapped beat
    slave_rdata = 32'h7F000000;
    applyStimulus(1'b0, 32'hFFFFFFFF, 2'd1, 1'b0, 32'h0);
`ifdef ARILLA_LSU_MISALIGNED_EN
    checkOutput("wrap_b0_addr", bus.address, 32'h3FFFFFFF);
    checkOutput("wrap_b0_be", bus.byte_enable, 4'b1000);
    tick();
    slave_avail = 1'b0;
    checkOutput("wrap_b1_addr", bus.address, 0);
    checkOutput("wrap_b1_be", bus.byte_enable, 4'b0001);
    tick();
`else
    checkOutput("wrap_no_bus", {bus.read, bus.write}, 0);
`endif
    checkOutput("wrap_rsp", {rsp_valid, rsp_fault}, 2'b11);
    checkOutput("wrap_rdata", rsp_rdata, 0);
    slave_avail = 1'b1;
    tick();

    // Dword size is illegal on a 32-bit bus
    applyStimulus(1'b0, 32'h300, 2'd3, 1'b0, 32'h0);
    checkOutput("ill_no_bus", {bus.read, bus.write}, 0);
    checkOutput("ill_rsp", {rsp_valid, rsp_fault}, 2'b11);
    tick();

    // Debug intercept without a slave completes the beat
    slave_avail = 1'b0;
    slave_icpt  = 1'b1;
    slave_rdata = 32'h12345678;
    applyStimulus(1'b0, 32'h300, 2'd2, 1'b0, 32'h0);
    tick();
    checkOutput("icpt_rsp", {rsp_valid, rsp_fault, rsp_intercepted}, 3'b101);
    tick();

    // Neither slave nor debug answers
    slave_icpt = 1'b0;
    applyStimulus(1'b0, 32'h400, 2'd2, 1'b0, 32'h0);
    tick();
    checkOutput("nos_rsp", {rsp_valid, rsp_fault, rsp_intercepted}, 3'b110);
    checkOutput("nos_rdata", rsp_rdata, 0);
    tick();

    // Reset in the middle of a beat abandons the access
    slave_avail = 1'b1;
    slave_rdata = 32'hCAFEF00D;
    applyStimulus(1'b0, 32'h100, 2'd2, 1'b0, 32'h0);
    checkOutput("mr_beat_active", bus.read, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mr_bus", {bus.read, bus.write, bus.byte_enable}, 0);
    checkOutput("mr_addr", bus.address, 0);
    checkOutput("mr_rsp", {rsp_valid, rsp_fault, rsp_intercepted}, 0);
    checkOutput("mr_rdata", rsp_rdata, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("mr_no_rsp", rsp_valid, 0);
    end

    // Normal service after the reset
    applyStimulus(1'b0, 32'h100, 2'd2, 1'b0, 32'h0);
    tick();
    checkOutput("post_rdata", rsp_rdata, 32'hCAFEF00D);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
